// File: rtl/counter_fabric_checker.sv
// counter_fabric_checker: compares the fabric's 8-bit counter outputs against
// an internal golden up-counter delayed by LATENCY register stages, and
// reports pass/fail, a saturating error count and first-mismatch details.
// Optional build macro COUNTER_CHECKER_STOP_ON_ERR_EN: end the check window
// on the first mismatch instead of running all CHECK_CYCLES samples.
module counter_fabric_checker #(
  parameter int WIDTH        = 8,
  parameter int LATENCY      = 1,
  parameter int CHECK_CYCLES = 512,
  parameter int ERR_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  dut_q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [15:0]       first_err_cycle,
  output logic [WIDTH-1:0]  first_err_exp,
  output logic [WIDTH-1:0]  first_err_got,
  output logic              wrap_seen
);

  typedef enum logic [1:0] {
    ST_RST_WAIT = 2'd0,
    ST_IDLE     = 2'd1,
    ST_CHECK    = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [2:0]  LAT_C    = 3'(LATENCY);
  localparam logic [15:0] LAST_IDX = 16'(CHECK_CYCLES - 1);

  // Saturating increment for the error counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_e             state_q;
  logic [2:0]         wait_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   exp_s;
  logic [15:0]        idx_q;
  logic [WIDTH-1:0]   prev_exp_q;
  logic               prev_valid_q;
  logic               busy_q, done_q, pass_q, mismatch_q, fe_valid_q, wrap_q;
  logic [ERR_W-1:0]   err_q;
  logic [15:0]        fe_cycle_q;
  logic [WIDTH-1:0]   fe_exp_q, fe_got_q;
  logic               miss_s;

  assign miss_s = (dut_q != exp_s);

  // Golden counter: free-running whenever reset is low, wraps modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  generate
    if (LATENCY == 0) begin : g_no_dly
      assign exp_s = cnt_q;
    end else begin : g_dly
      logic [WIDTH-1:0] dly_q [LATENCY];
      // Delay line aligning the golden value with the fabric output latency.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LATENCY; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= cnt_q;
          for (int i = 1; i < LATENCY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign exp_s = dly_q[LATENCY-1];
    end
  endgenerate

  // Checker FSM with all statistics and status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RST_WAIT;
      wait_q       <= 3'd0;
      idx_q        <= 16'd0;
      prev_exp_q   <= '0;
      prev_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      err_q        <= '0;
      fe_valid_q   <= 1'b0;
      fe_cycle_q   <= 16'd0;
      fe_exp_q     <= '0;
      fe_got_q     <= '0;
      wrap_q       <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        ST_RST_WAIT: begin
          // Wait until the delay line holds post-reset golden values.
          if (wait_q == LAT_C) begin
            state_q <= ST_IDLE;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_CHECK;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fe_valid_q   <= 1'b0;
            fe_cycle_q   <= 16'd0;
            fe_exp_q     <= '0;
            fe_got_q     <= '0;
            wrap_q       <= 1'b0;
            idx_q        <= 16'd0;
            prev_valid_q <= 1'b0;
          end
        end
        ST_CHECK: begin
          idx_q        <= idx_q + 16'd1;
          prev_exp_q   <= exp_s;
          prev_valid_q <= 1'b1;
          if (prev_valid_q && (&prev_exp_q) && (exp_s == '0)) begin
            wrap_q <= 1'b1;
          end
          if (miss_s) begin
            mismatch_q <= 1'b1;
            err_q      <= sat_inc(err_q);
            if (!fe_valid_q) begin
              fe_valid_q <= 1'b1;
              fe_cycle_q <= idx_q;
              fe_exp_q   <= exp_s;
              fe_got_q   <= dut_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !miss_s && (err_q == '0);
          end
`ifdef COUNTER_CHECKER_STOP_ON_ERR_EN
          if (miss_s && !fe_valid_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
          end
`endif
        end
        default: begin
          state_q <= ST_RST_WAIT;
          wait_q  <= 3'd0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign mismatch        = mismatch_q;
  assign err_count       = err_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_cycle = fe_cycle_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_got   = fe_got_q;
  assign wrap_seen       = wrap_q;

endmodule

// File: tb/tb_counter_fabric_checker.sv
// Directed bench for counter_fabric_checker: an ideal LATENCY=1 fabric model
// drives the main instance; a second instance with ERR_W=4 sees a stuck bus.
module tb_counter_fabric_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  gold_q, fab_q;
  logic [7:0]  inj = 8'h00;
  logic [7:0]  dut_q;
  logic [7:0]  stuck_q = 8'hFF;

  logic        busy, done, pass, mismatch, fev, wrap;
  logic [15:0] err, fec;
  logic [7:0]  fee, feg;
  logic        s_busy, s_done, s_pass, s_mismatch, s_fev, s_wrap;
  logic [3:0]  s_err;
  logic [15:0] s_fec;
  logic [7:0]  s_fee, s_feg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Ideal fabric: golden counter plus one output register stage.
  always @(posedge clk) begin
    if (reset) begin
      gold_q <= 8'h00;
      fab_q  <= 8'h00;
    end else begin
      gold_q <= gold_q + 8'd1;
      fab_q  <= gold_q;
    end
  end

  assign dut_q = fab_q ^ inj;

  counter_fabric_checker #(.WIDTH(8), .LATENCY(1), .CHECK_CYCLES(512), .ERR_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_q(dut_q),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .err_count(err),
    .first_err_valid(fev), .first_err_cycle(fec), .first_err_exp(fee),
    .first_err_got(feg), .wrap_seen(wrap)
  );

  counter_fabric_checker #(.WIDTH(8), .LATENCY(1), .CHECK_CYCLES(512), .ERR_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .dut_q(stuck_q),
    .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mismatch), .err_count(s_err),
    .first_err_valid(s_fev), .first_err_cycle(s_fec), .first_err_exp(s_fee),
    .first_err_got(s_feg), .wrap_seen(s_wrap)
  );

  // Pulse start for one edge; returns at the negedge right after that edge.
  task automatic open_window();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs from the negedge after the opening edge (n=0) until done is seen.
  // Input driven at negedge n is sampled as sample index n.
  task automatic run_to_done(input int inj_at, input logic [7:0] mask, input int start_at,
                             output int busy_n, output int mis_n, output int smis_n,
                             output int mis_first, output logic [7:0] exp_at,
                             output bit finished);
    busy_n = 0; mis_n = 0; smis_n = 0; mis_first = -1; exp_at = 8'h00; finished = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (busy) busy_n++;
      if (mismatch) begin
        mis_n++;
        if (mis_first < 0) mis_first = n;
      end
      if (s_mismatch) smis_n++;
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (n == inj_at) exp_at = fab_q;
      inj   = (n == inj_at) ? mask : 8'h00;
      start = (n == start_at);
      @(negedge clk);
    end
    inj   = 8'h00;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, pass, mismatch, fev, wrap} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {busy, done, pass, mismatch, fev, wrap}); end
    checks++; if (err !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err); end
    checks++; if (s_err !== 4'd0) begin errors++; $display("FAIL reset_sat_err: got %0d expected 0", s_err); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ideal();
    int b, m, sm, mf; logic [7:0] ea; bit fin;
    open_window();
    run_to_done(-1, 8'h00, -1, b, m, sm, mf, ea, fin);
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL ideal_timeout: got done=%0d expected 1", fin); end
    checks++; if (b !== 512) begin errors++; $display("FAIL ideal_len: got %0d expected 512", b); end
    checks++; if (m !== 0) begin errors++; $display("FAIL ideal_mismatch: got %0d expected 0", m); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ideal_pass: got %0d expected 1", pass); end
    checks++; if (err !== 16'd0) begin errors++; $display("FAIL ideal_err: got %0d expected 0", err); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL ideal_wrap: got %0d expected 1", wrap); end
    checks++; if (fev !== 1'b0) begin errors++; $display("FAIL ideal_fev: got %0d expected 0", fev); end
  endtask

  task automatic test_single_error();
    int b, m, sm, mf; logic [7:0] ea; bit fin;
    open_window();
    run_to_done(100, 8'h04, -1, b, m, sm, mf, ea, fin);
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL single_timeout: got done=%0d expected 1", fin); end
    checks++; if (m !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", m); end
    checks++; if (mf !== 101) begin errors++; $display("FAIL single_pulse_time: got %0d expected 101", mf); end
    checks++; if (err !== 16'd1) begin errors++; $display("FAIL single_err: got %0d expected 1", err); end
    checks++; if (fec !== 16'd100) begin errors++; $display("FAIL single_cycle: got %0d expected 100", fec); end
    checks++; if (fee !== ea) begin errors++; $display("FAIL single_exp: got %h expected %h", fee, ea); end
    checks++; if (feg !== (ea ^ 8'h04)) begin errors++; $display("FAIL single_got: got %h expected %h", feg, ea ^ 8'h04); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL single_pass: got %0d expected 0", pass); end
  endtask

  task automatic test_restart_from_done();
    int b, m, sm, mf; logic [7:0] ea; bit fin;
    open_window();
    checks++; if ({busy, done, fev} !== 3'b100) begin errors++; $display("FAIL restart_flags: got %b expected 100", {busy, done, fev}); end
    checks++; if (err !== 16'd0) begin errors++; $display("FAIL restart_err: got %0d expected 0", err); end
    run_to_done(-1, 8'h00, 50, b, m, sm, mf, ea, fin);
    checks++; if (b !== 512) begin errors++; $display("FAIL start_in_check_len: got %0d expected 512", b); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL restart_pass: got %0d expected 1", pass); end
  endtask

  task automatic test_saturation();
    int b, m, sm, mf; logic [7:0] ea; bit fin;
    open_window();
    run_to_done(-1, 8'h00, -1, b, m, sm, mf, ea, fin);
    checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL sat_done: got %0d expected 1", s_done); end
    checks++; if (s_err !== 4'd15) begin errors++; $display("FAIL sat_err: got %0d expected 15", s_err); end
    checks++; if (sm !== 510) begin errors++; $display("FAIL sat_pulses: got %0d expected 510", sm); end
    checks++; if (s_pass !== 1'b0) begin errors++; $display("FAIL sat_pass: got %0d expected 0", s_pass); end
    checks++; if (s_feg !== 8'hFF) begin errors++; $display("FAIL sat_got: got %h expected ff", s_feg); end
  endtask

  task automatic test_reset_mid_check();
    int b, m, sm, mf; logic [7:0] ea; bit fin;
    open_window();
    repeat (200) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, pass, mismatch, fev, wrap} !== 6'b0) begin errors++; $display("FAIL midreset_flags: got %b expected 000000", {busy, done, pass, mismatch, fev, wrap}); end
    checks++; if ({err, fec} !== 32'd0) begin errors++; $display("FAIL midreset_stats: got %h expected 0", {err, fec}); end
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstwait_start: got busy=%0d expected 0", busy); end
    open_window();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL after_rstwait_start: got busy=%0d expected 1", busy); end
    run_to_done(-1, 8'h00, -1, b, m, sm, mf, ea, fin);
    checks++; if (b !== 512) begin errors++; $display("FAIL after_reset_len: got %0d expected 512", b); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL after_reset_pass: got %0d expected 1", pass); end
  endtask

  task automatic test_stop_on_err();
    int b, m, sm, mf; logic [7:0] ea; bit fin; int exp_len;
`ifdef COUNTER_CHECKER_STOP_ON_ERR_EN
    exp_len = 11;
`else
    exp_len = 512;
`endif
    open_window();
    run_to_done(10, 8'h01, -1, b, m, sm, mf, ea, fin);
    checks++; if (b !== exp_len) begin errors++; $display("FAIL stop_len: got %0d expected %0d", b, exp_len); end
    checks++; if (err !== 16'd1) begin errors++; $display("FAIL stop_err: got %0d expected 1", err); end
    checks++; if (fec !== 16'd10) begin errors++; $display("FAIL stop_cycle: got %0d expected 10", fec); end
    checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL stop_done_pass: got %b expected 10", {done, pass}); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_single_error();
    test_restart_from_done();
    test_saturation();
    test_reset_mid_check();
    test_stop_on_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
